bicubic_row_assembler: RTL and testbench
========================================

# bicubic_row_assembler

Downstream stage of the 4x bicubic upsampler. It consumes 4x4 output blocks, delivered as four beats of four pixels (block row 0..3), and reorders them into a raster-order stream of four pixels per beat. Two row-group banks are used ping-pong: one bank fills while the other drains. The output feeds the frame writer / output stream interface.

## Interface
- CHANNEL_WIDTH, 8: bits per pixel channel.
- BLK_PER_ROW, 8: 4x4 blocks per input row (= source image width); range 2..64.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- bcci_rsp_valid  in  1  upsampler beat valid.
- ra_req_ready  out  1  assembler accepts beat.
- bcci_rsp_data1..4  in  CHANNEL_WIDTH each  output-block row pixels, left to right.
- ra_rsp_valid  out  1  raster beat valid.
- out_rsp_ready  in  1  downstream accepts raster beat.
- ra_rsp_data1..4  out  CHANNEL_WIDTH each  four horizontally adjacent output pixels.
- ra_rsp_eol  out  1  last beat of an output row.
- ra_rsp_eog  out  1  last beat of a 4-row group (bank drained).

## Operation
- Each bank holds 4 rows of 4*BLK_PER_ROW pixels in a flop array, plus a full flag.
- Write side:
  - wr_bank (1b), wr_blk (0..BLK_PER_ROW-1) and wr_row (0..3).
  - A beat is accepted on bcci_rsp_valid & ra_req_ready.
  - An accepted beat writes row wr_row, columns 4*wr_blk .. 4*wr_blk+3 of wr_bank.
  - Counters: wr_row increments; on wrap 3->0, wr_blk increments.
  - On the last beat (wr_blk=BLK_PER_ROW-1, wr_row=3): set full[wr_bank], toggle wr_bank, clear both counters.
- ra_req_ready = ~full[wr_bank].
- Read side:
  - rd_bank, rd_row (0..3) and rd_blk (0..BLK_PER_ROW-1).
  - ra_rsp_valid = full[rd_bank].
  - Data is row rd_row, columns 4*rd_blk .. +3 of rd_bank, read combinationally from the flops.
  - A beat is consumed on ra_rsp_valid & out_rsp_ready.
  - Counters: rd_blk increments; on wrap, rd_row increments.
  - On the last beat: clear full[rd_bank], toggle rd_bank, clear counters.
- ra_rsp_eol = ra_rsp_valid & (rd_blk==BLK_PER_ROW-1).
- ra_rsp_eog = ra_rsp_eol & (rd_row==3).
- Pixel values pass through unmodified; there is no arithmetic.

## Timing
- Reset values:
  - ra_req_ready=1, ra_rsp_valid=0, ra_rsp_eol=0, ra_rsp_eog=0.
  - Both full flags 0; all counters and bank pointers 0.
  - Data outputs are don't-care while valid=0; the bank array is not reset.
- Latency: a bank's last write at cycle N makes ra_rsp_valid=1 at cycle N+1. There is no combinational path from bcci_rsp_valid to ra_rsp_valid.
- ra_req_ready depends only on registered state. It never depends combinationally on bcci_rsp_valid or out_rsp_ready, because the upstream valid is itself combinational.
- Valid/data hold stable while ra_rsp_valid & ~out_rsp_ready.
- Both banks full: ra_req_ready=0 until the drain of rd_bank completes. ready returns in the cycle after the last read beat.
- Simultaneous last write to bank A and last read from bank B in one cycle: full[A] is set and full[B] is cleared in the same edge, and both pointers toggle.
- Throughput: 1 beat/cycle each side with no bubbles when both sides are saturated.
- rst_n low mid-frame: state is discarded next edge. Partial banks are lost, and the stream restarts at block 0 row 0.

## Structure
- Shared package holds CHANNEL_WIDTH, UPSCALE=4 and the BLK_PER_ROW default. The fixed beats-per-block = 4 is derived from UPSCALE.
- One sub-module, bicubic_ra_bank, is instantiated twice. It contains:
  - the 4 x 4*BLK_PER_ROW pixel flop array;
  - a write port (en, row, blk, 4 pixels);
  - a combinational read mux (row, blk -> 4 pixels).
- The top holds the full flags, counters, pointers and the handshake logic (about 200 lines total).

## Test plan
All scenarios use BLK_PER_ROW=2. Input pixel (block b, beat r, lane l) = 16b+4r+l.
- Reset then one group, out_rsp_ready=1:
  - 8 input beats, then ra_rsp_valid rises 1 cycle after the 8th.
  - Output beats: {0,1,2,3}, {16..19}, {4..7}, {20..23}, {8..11}, {24..27}, {12..15}, {28..31}.
  - eol on beats 2, 4, 6, 8; eog on beat 8.
- out_rsp_ready=0, 16 input beats offered:
  - Both banks fill; ra_req_ready=0 from the cycle after the 16th accepted beat.
  - The 17th beat is held off.
  - Releasing ready drains bank 0, then ready reasserts.
- Continuous streaming, both sides always valid/ready for 5 groups:
  - No bubbles after the first group.
  - Group k output equals group k input reordered as above.
- Output backpressure toggling every other cycle:
  - Data/eol stay stable while stalled; no beat is lost or duplicated.
- Simultaneous event: arrange last write to bank 1 in the same cycle as last read of bank 0.
  - Next cycle: full={1,0}, ra_rsp_valid=1 from bank 1, ra_req_ready=1.
- rst_n low for 1 cycle after 5 input beats:
  - Outputs return to reset values.
  - The next 8 beats produce the group exactly as in the first scenario.

Source files
------------

// File: rtl/bicubic_row_assembler_pkg.sv
// Shared constants, types and helpers for the bicubic row assembler slice.
package bicubic_row_assembler_pkg;

  localparam int CHANNEL_WIDTH       = 8;
  localparam int UPSCALE             = 4;
  localparam int BEATS_PER_BLK       = UPSCALE;
  localparam int BLK_PER_ROW_DEFAULT = 8;
  localparam int ROW_W               = $clog2(BEATS_PER_BLK);

  typedef logic [CHANNEL_WIDTH-1:0] pixel_t;

  // One beat: UPSCALE pixels, lane 0 is the leftmost pixel.
  typedef logic [UPSCALE-1:0][CHANNEL_WIDTH-1:0] pix_vec_t;

  // Ping-pong bank selector.
  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_t;

  function automatic bank_t other_bank(input bank_t b);
    return (b == BANK_0) ? BANK_1 : BANK_0;
  endfunction

  // Index width that stays at least one bit wide for tiny ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bicubic_row_assembler_if.sv
// Handshake and pixel bus between upsampler, row assembler and output stream.
interface bicubic_row_assembler_if;
  import bicubic_row_assembler_pkg::*;

  logic   bcci_rsp_valid;
  logic   ra_req_ready;
  pixel_t bcci_rsp_data1;
  pixel_t bcci_rsp_data2;
  pixel_t bcci_rsp_data3;
  pixel_t bcci_rsp_data4;

  logic   ra_rsp_valid;
  logic   out_rsp_ready;
  pixel_t ra_rsp_data1;
  pixel_t ra_rsp_data2;
  pixel_t ra_rsp_data3;
  pixel_t ra_rsp_data4;
  logic   ra_rsp_eol;
  logic   ra_rsp_eog;

  // Assembler side.
  modport slave (
    input  bcci_rsp_valid, bcci_rsp_data1, bcci_rsp_data2, bcci_rsp_data3, bcci_rsp_data4,
    input  out_rsp_ready,
    output ra_req_ready,
    output ra_rsp_valid, ra_rsp_data1, ra_rsp_data2, ra_rsp_data3, ra_rsp_data4,
    output ra_rsp_eol, ra_rsp_eog
  );

  // Environment side: drives upsampler beats and downstream ready.
  modport master (
    output bcci_rsp_valid, bcci_rsp_data1, bcci_rsp_data2, bcci_rsp_data3, bcci_rsp_data4,
    output out_rsp_ready,
    input  ra_req_ready,
    input  ra_rsp_valid, ra_rsp_data1, ra_rsp_data2, ra_rsp_data3, ra_rsp_data4,
    input  ra_rsp_eol, ra_rsp_eog
  );

endinterface

// File: rtl/bicubic_ra_bank.sv
// One row-group bank: 4 rows x 4*BLK_PER_ROW pixels held in flops,
// written one 4-pixel block row at a time and read combinationally.
module bicubic_ra_bank
  import bicubic_row_assembler_pkg::*;
#(
  parameter int  BLK_PER_ROW = BLK_PER_ROW_DEFAULT,
  localparam int BLK_W       = idx_width(BLK_PER_ROW)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [BLK_W-1:0] wr_blk,
  input  pix_vec_t         wr_data,
  input  logic [ROW_W-1:0] rd_row,
  input  logic [BLK_W-1:0] rd_blk,
  output pix_vec_t         rd_data
);

  pix_vec_t mem [BEATS_PER_BLK][BLK_PER_ROW];

  // Pixel storage is deliberately not reset; the full flags gate its use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row][wr_blk] <= wr_data;
    end
  end

  assign rd_data = mem[rd_row][rd_blk];

endmodule

// File: rtl/bicubic_row_assembler.sv
// Reorders 4x4 output blocks (four beats per block) into a raster stream of
// four pixels per beat, using two row-group banks in ping-pong fashion.
module bicubic_row_assembler
  import bicubic_row_assembler_pkg::*;
#(
  parameter int BLK_PER_ROW = BLK_PER_ROW_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  bicubic_row_assembler_if.slave        bus
);

  localparam int               BLK_W    = idx_width(BLK_PER_ROW);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLK_PER_ROW - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BEATS_PER_BLK - 1);

  logic [1:0]       full;
  bank_t            wr_bank;
  bank_t            rd_bank;
  logic [ROW_W-1:0] wr_row;
  logic [ROW_W-1:0] rd_row;
  logic [BLK_W-1:0] wr_blk;
  logic [BLK_W-1:0] rd_blk;

  logic     wr_fire;
  logic     rd_fire;
  logic     wr_last;
  logic     rd_last;
  logic     rsp_valid;
  pix_vec_t wr_data;
  pix_vec_t rd_data;
  pix_vec_t bank_rd_data [2];

  // Ready and valid come only from the full flags so that upstream's
  // combinational valid never loops back into ready.
  assign bus.ra_req_ready = ~full[wr_bank];
  assign rsp_valid        = full[rd_bank];
  assign bus.ra_rsp_valid = rsp_valid;

  assign wr_fire = bus.bcci_rsp_valid & ~full[wr_bank];
  assign rd_fire = rsp_valid & bus.out_rsp_ready;
  assign wr_last = (wr_blk == LAST_BLK) && (wr_row == LAST_ROW);
  assign rd_last = (rd_blk == LAST_BLK) && (rd_row == LAST_ROW);

  assign wr_data = {bus.bcci_rsp_data4, bus.bcci_rsp_data3,
                    bus.bcci_rsp_data2, bus.bcci_rsp_data1};

  // Write side walks the beats of a block first, then moves to the next block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank <= BANK_0;
      wr_row  <= '0;
      wr_blk  <= '0;
    end else if (wr_fire) begin
      if (wr_last) begin
        wr_bank <= other_bank(wr_bank);
        wr_row  <= '0;
        wr_blk  <= '0;
      end else if (wr_row == LAST_ROW) begin
        wr_row <= '0;
        wr_blk <= wr_blk + 1'b1;
      end else begin
        wr_row <= wr_row + 1'b1;
      end
    end
  end

  // Read side walks across a whole output row before moving down a row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bank <= BANK_0;
      rd_row  <= '0;
      rd_blk  <= '0;
    end else if (rd_fire) begin
      if (rd_last) begin
        rd_bank <= other_bank(rd_bank);
        rd_row  <= '0;
        rd_blk  <= '0;
      end else if (rd_blk == LAST_BLK) begin
        rd_blk <= '0;
        rd_row <= rd_row + 1'b1;
      end else begin
        rd_blk <= rd_blk + 1'b1;
      end
    end
  end

  // Full flags: set on a bank's last write, cleared on its last read. The
  // two events always target different banks, so both may land together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      if (wr_fire && wr_last) begin
        full[wr_bank] <= 1'b1;
      end
      if (rd_fire && rd_last) begin
        full[rd_bank] <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_bank
    bicubic_ra_bank #(
      .BLK_PER_ROW (BLK_PER_ROW)
    ) u_bank (
      .clk     (clk),
      .wr_en   (wr_fire && (wr_bank == bank_t'(i))),
      .wr_row  (wr_row),
      .wr_blk  (wr_blk),
      .wr_data (wr_data),
      .rd_row  (rd_row),
      .rd_blk  (rd_blk),
      .rd_data (bank_rd_data[i])
    );
  end

  assign rd_data = bank_rd_data[rd_bank];

  assign bus.ra_rsp_data1 = rd_data[0];
  assign bus.ra_rsp_data2 = rd_data[1];
  assign bus.ra_rsp_data3 = rd_data[2];
  assign bus.ra_rsp_data4 = rd_data[3];

  assign bus.ra_rsp_eol = rsp_valid & (rd_blk == LAST_BLK);
  assign bus.ra_rsp_eog = rsp_valid & (rd_blk == LAST_BLK) & (rd_row == LAST_ROW);

endmodule

// File: tb/tb_bicubic_row_assembler.sv
// Self-checking bench for bicubic_row_assembler with BLK_PER_ROW=2.
// A queue-based reference model tracks completed groups and their raster order.
module tb_bicubic_row_assembler;
  import bicubic_row_assembler_pkg::*;

  localparam int BLK         = 2;
  localparam int GROUP_BEATS = BEATS_PER_BLK * BLK;
  localparam int BW          = 4 * CHANNEL_WIDTH;

  typedef logic [BW-1:0] beat_t;
  typedef struct packed {
    beat_t data;
    logic  eol;
    logic  eog;
  } exp_beat_t;
  typedef logic [BW+3:0] obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  beat_t     in_beats[$];
  exp_beat_t exp_q[$];
  int        pending = 0;

  int unsigned first_pix [GROUP_BEATS] = '{0, 16, 4, 20, 8, 24, 12, 28};

  bicubic_row_assembler_if bus();

  bicubic_row_assembler #(
    .BLK_PER_ROW (BLK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic beat_t pix_beat(input int unsigned base);
    beat_t b;
    for (int l = 0; l < 4; l++) b[l*CHANNEL_WIDTH +: CHANNEL_WIDTH] = CHANNEL_WIDTH'(base + l);
    return b;
  endfunction

  function automatic beat_t seq_beat(input int k);
    return pix_beat(4 * k);
  endfunction

  function automatic beat_t rand_beat();
    return beat_t'($urandom);
  endfunction

  function automatic beat_t out_beat();
    return {bus.ra_rsp_data4, bus.ra_rsp_data3, bus.ra_rsp_data2, bus.ra_rsp_data1};
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = {bus.ra_rsp_valid, bus.ra_req_ready, bus.ra_rsp_eol, bus.ra_rsp_eog, beat_t'(0)};
    if (bus.ra_rsp_valid === 1'b1) o[BW-1:0] = out_beat();
    return o;
  endfunction

  // Expected outputs: valid whenever a completed group is waiting, ready
  // unless two completed groups are waiting.
  function automatic obs_t model_out();
    obs_t o;
    o = '0;
    o[BW+3] = (pending > 0);
    o[BW+2] = (pending < 2);
    if (pending > 0) begin
      o[BW+1]   = exp_q[0].eol;
      o[BW]     = exp_q[0].eog;
      o[BW-1:0] = exp_q[0].data;
    end
    return o;
  endfunction

  task automatic drive_in(input logic v, input beat_t b);
    bus.bcci_rsp_valid = v;
    bus.bcci_rsp_data1 = b[0*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    bus.bcci_rsp_data2 = b[1*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    bus.bcci_rsp_data3 = b[2*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    bus.bcci_rsp_data4 = b[3*CHANNEL_WIDTH +: CHANNEL_WIDTH];
  endtask

  // Advance one clock and update the reference model; called at a negedge.
  task automatic tick();
    logic  acc;
    logic  cons;
    beat_t cur;
    acc  = rst_n && bus.bcci_rsp_valid && (pending < 2);
    cons = rst_n && bus.out_rsp_ready && (pending > 0);
    cur  = {bus.bcci_rsp_data4, bus.bcci_rsp_data3, bus.bcci_rsp_data2, bus.bcci_rsp_data1};
    @(posedge clk);
    if (!rst_n) begin
      in_beats.delete();
      exp_q.delete();
      pending = 0;
    end else begin
      if (cons) begin
        if (exp_q[0].eog) pending--;
        void'(exp_q.pop_front());
      end
      if (acc) begin
        in_beats.push_back(cur);
        if (in_beats.size() == GROUP_BEATS) begin
          for (int r = 0; r < BEATS_PER_BLK; r++) begin
            for (int b = 0; b < BLK; b++) begin
              exp_beat_t e;
              e.data = in_beats[b*BEATS_PER_BLK + r];
              e.eol  = (b == BLK - 1);
              e.eog  = (b == BLK - 1) && (r == BEATS_PER_BLK - 1);
              exp_q.push_back(e);
            end
          end
          in_beats.delete();
          pending++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive_in(1'b0, '0);
    bus.out_rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_in(1'b1, rand_beat());
    bus.out_rsp_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.ra_req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready: got %b want 1", bus.ra_req_ready);
    end
    checks++;
    if (bus.ra_rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b want 0", bus.ra_rsp_valid);
    end
    checks++;
    if (bus.ra_rsp_eol !== 1'b0 || bus.ra_rsp_eog !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_eol_eog: got %b%b want 00", bus.ra_rsp_eol, bus.ra_rsp_eog);
    end
    rst_n = 1'b1;
    drive_in(1'b0, '0);
    checks++;
    if (observe() !== model_out()) begin
      errors++; $display("[TB] FAIL reset_model: got %h want %h", observe(), model_out());
    end
  endtask

  task automatic test_single_group(input string tag);
    int j = 0;
    bus.out_rsp_ready = 1'b1;
    for (int t = 0; t < 17; t++) begin
      drive_in(t < GROUP_BEATS, (t < GROUP_BEATS) ? seq_beat(t) : beat_t'(0));
      checks++;
      if (observe() !== model_out()) begin
        errors++; $display("[TB] FAIL %s cyc %0d: got %h want %h", tag, t, observe(), model_out());
      end
      if (t == GROUP_BEATS - 1 || t == GROUP_BEATS) begin
        checks++;
        if (bus.ra_rsp_valid !== (t == GROUP_BEATS)) begin
          errors++; $display("[TB] FAIL %s valid_latency cyc %0d: got %b want %b",
                             tag, t, bus.ra_rsp_valid, (t == GROUP_BEATS));
        end
      end
      if (bus.ra_rsp_valid === 1'b1) begin
        checks++;
        if (j >= GROUP_BEATS) begin
          errors++; $display("[TB] FAIL %s extra_beat %0d: got %h want none", tag, j, out_beat());
        end else if ({out_beat(), bus.ra_rsp_eol, bus.ra_rsp_eog} !==
                     {pix_beat(first_pix[j]), (j % 2 == 1), (j == GROUP_BEATS - 1)}) begin
          errors++; $display("[TB] FAIL %s beat %0d: got %h eol %b eog %b want %h eol %b eog %b",
                             tag, j, out_beat(), bus.ra_rsp_eol, bus.ra_rsp_eog,
                             pix_beat(first_pix[j]), (j % 2 == 1), (j == GROUP_BEATS - 1));
        end
        j++;
      end
      tick();
    end
    checks++;
    if (j != GROUP_BEATS) begin
      errors++; $display("[TB] FAIL %s beat_count: got %0d want %0d", tag, j, GROUP_BEATS);
    end
  endtask

  task automatic test_fill_both_banks();
    int k = 0;
    logic fire;
    apply_reset();
    bus.out_rsp_ready = 1'b0;
    for (int t = 0; t < 20; t++) begin
      drive_in(1'b1, seq_beat(k));
      checks++;
      if (observe() !== model_out()) begin
        errors++; $display("[TB] FAIL fill cyc %0d: got %h want %h", t, observe(), model_out());
      end
      fire = (bus.ra_req_ready === 1'b1);
      tick();
      if (fire) k++;
    end
    checks++;
    if (k != 2 * GROUP_BEATS || bus.ra_req_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL fill_holdoff: got accepted %0d ready %b want accepted %0d ready 0",
                         k, bus.ra_req_ready, 2 * GROUP_BEATS);
    end
    bus.out_rsp_ready = 1'b1;
    for (int t = 0; t < GROUP_BEATS; t++) begin
      checks++;
      if (observe() !== model_out()) begin
        errors++; $display("[TB] FAIL drain0 cyc %0d: got %h want %h", t, observe(), model_out());
      end
      tick();
    end
    checks++;
    if (bus.ra_req_ready !== 1'b1 || bus.ra_rsp_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL drain0_ready: got ready %b valid %b want 1 1",
                         bus.ra_req_ready, bus.ra_rsp_valid);
    end
    drive_in(1'b0, '0);
    for (int t = 0; t < GROUP_BEATS + 2; t++) begin
      checks++;
      if (observe() !== model_out()) begin
        errors++; $display("[TB] FAIL drain1 cyc %0d: got %h want %h", t, observe(), model_out());
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int consumed = 0;
    apply_reset();
    bus.out_rsp_ready = 1'b1;
    for (int t = 0; t < 6 * GROUP_BEATS + 2; t++) begin
      drive_in(t < 5 * GROUP_BEATS, rand_beat());
      checks++;
      if (observe() !== model_out()) begin
        errors++; $display("[TB] FAIL stream cyc %0d: got %h want %h", t, observe(), model_out());
      end
      if (t >= GROUP_BEATS && t < 6 * GROUP_BEATS && bus.ra_rsp_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL stream_bubble cyc %0d: got valid %b want 1", t, bus.ra_rsp_valid);
      end
      if (bus.ra_rsp_valid === 1'b1) consumed++;
      tick();
    end
    checks++;
    if (consumed != 5 * GROUP_BEATS) begin
      errors++; $display("[TB] FAIL stream_count: got %0d want %0d", consumed, 5 * GROUP_BEATS);
    end
  endtask

  task automatic test_toggle_backpressure();
    logic  prev_stall = 1'b0;
    beat_t prev_data  = '0;
    logic  prev_eol   = 1'b0;
    apply_reset();
    for (int t = 0; t < 110; t++) begin
      drive_in((t < 70) && ($urandom_range(0, 3) != 0), rand_beat());
      bus.out_rsp_ready = (t % 2 == 1);
      checks++;
      if (observe() !== model_out()) begin
        errors++; $display("[TB] FAIL toggle cyc %0d: got %h want %h", t, observe(), model_out());
      end
      if (prev_stall) begin
        checks++;
        if (bus.ra_rsp_valid !== 1'b1 || out_beat() !== prev_data || bus.ra_rsp_eol !== prev_eol) begin
          errors++; $display("[TB] FAIL toggle_hold cyc %0d: got v%b %h eol %b want v1 %h eol %b",
                             t, bus.ra_rsp_valid, out_beat(), bus.ra_rsp_eol, prev_data, prev_eol);
        end
      end
      prev_stall = (bus.ra_rsp_valid === 1'b1) && !bus.out_rsp_ready;
      prev_data  = out_beat();
      prev_eol   = bus.ra_rsp_eol;
      tick();
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    bus.out_rsp_ready = 1'b1;
    for (int t = 0; t < 3 * GROUP_BEATS; t++) begin
      drive_in(t < 2 * GROUP_BEATS, seq_beat(t));
      checks++;
      if (observe() !== model_out()) begin
        errors++; $display("[TB] FAIL simul cyc %0d: got %h want %h", t, observe(), model_out());
      end
      if (t == 2 * GROUP_BEATS - 1) begin
        checks++;
        if (bus.ra_rsp_eog !== 1'b1 || bus.ra_req_ready !== 1'b1) begin
          errors++; $display("[TB] FAIL simul_edge: got eog %b ready %b want 1 1",
                             bus.ra_rsp_eog, bus.ra_req_ready);
        end
      end
      if (t == 2 * GROUP_BEATS) begin
        checks++;
        if ({bus.ra_rsp_valid, bus.ra_req_ready, out_beat()} !== {2'b11, seq_beat(GROUP_BEATS)}) begin
          errors++; $display("[TB] FAIL simul_after: got v%b r%b %h want v1 r1 %h",
                             bus.ra_rsp_valid, bus.ra_req_ready, out_beat(), seq_beat(GROUP_BEATS));
        end
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    bus.out_rsp_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      drive_in(1'b1, rand_beat());
      tick();
    end
    rst_n = 1'b0;
    drive_in(1'b0, '0);
    tick();
    rst_n = 1'b1;
    checks++;
    if ({bus.ra_rsp_valid, bus.ra_req_ready, bus.ra_rsp_eol, bus.ra_rsp_eog} !== 4'b0100) begin
      errors++; $display("[TB] FAIL midreset_outputs: got %b%b%b%b want 0100",
                         bus.ra_rsp_valid, bus.ra_req_ready, bus.ra_rsp_eol, bus.ra_rsp_eog);
    end
    test_single_group("midreset_group");
  endtask

  initial begin
    drive_in(1'b0, '0);
    bus.out_rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_group("single_group");
    test_fill_both_banks();
    test_back_to_back();
    test_toggle_backpressure();
    test_simultaneous();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
